conv_seq_ctrl: RTL and testbench
================================

# conv_seq_ctrl

Sequencing controller for the single-lane convolution datapath (padded activation buffer, filter buffer, shared multiplier, accumulator, result array). On `start` it loads an AS×AS activation tile and an FS×FS filter over valid/ready streams. It then walks every output position, running FS·FS multiply-accumulate steps at each, and streams the OS×OS results out. It owns the loop counters that mirror the datapath's row, column and shift counters, and it produces every datapath load, step and clear strobe.

## Interface
- `AS`, 6: activation side; must be ≤ 8 because the datapath counters are 3 bits wide.
- `FS`, 3: filter side, ≤ AS.
- `STR`, 1: stride; the shift counters advance by STR.
- `ZP`, 0: zero padding.
- `OS`, derived: ((AS+2·ZP−FS)/STR)+1; not overridable.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: begin a job; sampled only in IDLE.
- `abort` in 1: synchronous abandon; returns to IDLE.
- `a_vld` in 1: activation word valid.
- `f_vld` in 1: filter word valid.
- `a_rdy` out 1: activation word accepted when `a_vld & a_rdy`.
- `f_rdy` out 1: filter word accepted when `f_vld & f_rdy`.
- `out_vld` out 1: datapath `out` holds a valid result.
- `out_rdy` in 1: downstream accepts the result.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse after the last result is accepted.
- `clr`, `rclr`, `cclr`, `sftrclr`, `sftcclr` out 1 each: datapath clears.
- `l`, `fl`, `mull`, `addl`, `resultl`, `outl` out 1 each: datapath loads.
- `rl`, `cl`, `sftrl`, `sftcl` out 1 each: datapath counter increments.
- `state` out 4: current state encoding, for debug.

## Operation
- States: IDLE, INIT, LOAD_A, LOAD_F, MCLR, MUL, ACC, STORE, SHIFT, OUT_RD, OUT_WAIT, FIN.
- Strobe outputs are Moore/registered-free combinational decodes of state plus handshakes. Every strobe is 0 in IDLE.
- IDLE→INIT on `start`.
- INIT lasts 1 cycle and pulses `clr`, `rclr`, `cclr`, `sftrclr`, `sftcclr`. Internal `rc`, `cc`, `sr`, `sc` are set to 0. Next state is LOAD_A.
- Row/column step rule, used everywhere: `cl=1`, `cc++`. When `cc` is at limit−1, instead assert `cclr` and `rl`, set `cc=0` and `rc++`. When `rc` is also at limit−1, the counter wraps to (0,0): `rclr` and `cclr` are asserted and the phase ends.
- LOAD_A (limit AS): `a_rdy=1`. Each `a_vld` beat asserts `l` and steps. After AS·AS beats, go to LOAD_F.
- LOAD_F (limit FS): `f_rdy=1`. Each `f_vld` beat asserts `fl` and steps. After FS·FS beats, go to MCLR.
- MCLR: pulse `clr` (zeroes mul/add), then MUL.
- MUL: `mull=1`, then ACC.
- ACC: `addl=1` and step (limit FS). If it is not the last element, go to MUL; otherwise go to STORE.
- STORE: `resultl=1`, then SHIFT.
- SHIFT: `sftcl=1`, `sc+=STR`. When `sc==(OS−1)·STR`: `sftcclr`, `sftrl`, `sc=0`, `sr+=STR`. When `sr` is also at its end: `sftrclr`, `sftcclr`, and go to OUT_RD. Otherwise go to MCLR.
- OUT_RD: `outl=1`, then OUT_WAIT.
- OUT_WAIT: `out_vld=1`, held until `out_rdy`. On acceptance, step (limit OS). Go back to OUT_RD, or to FIN after OS·OS results.
- FIN: `done=1` for 1 cycle, then IDLE.
- `abort` in any non-IDLE state: go to INIT-style clears for 1 cycle, then IDLE; `done` is not asserted. `abort` has priority over handshakes in the same cycle.
- `start` while busy is ignored. `a_vld`/`f_vld` outside their load state are ignored, and the corresponding ready stays 0.

## Timing
- Reset values: state=IDLE, all counters 0, every output 0.
- `rst` mid-job: immediate IDLE. The datapath is reset by the same `rst`.
- Load throughput is 1 word per cycle while valid is held.
- Compute per output: 1 (MCLR) + 2·FS·FS + 1 (STORE) + 1 (SHIFT) cycles. With defaults this is 21 cycles × 16 outputs = 336.
- Output throughput is 1 result per 2 cycles with `out_rdy` held high.
- `out_vld` rises the cycle after `outl`, once `out` is registered.

## Configuration
- `CONV_SEQ_PIPE_EN` defined: MAC is overlapped. MUL runs only for the first element of each output. After that, one state asserts `mull` for element k+1 and `addl` for element k together. A final ACC drains the last element.
  - Per-output cost: FS·FS+4 cycles, which is 13 with defaults.
  - The step rule is applied on the combined `mull`/`addl` cycle.
- `CONV_SEQ_PIPE_EN` undefined: strict MUL/ACC alternation, exactly as specified above.

## Test plan
- Defaults: `start`, then 36 `a` beats and 9 `f` beats with valid always high → `busy` is high for exactly 2+36+9+336+32 cycles and `done` pulses once. `rl` count: 6 during load-A, 3 during load-F.
- Stall loading: `a_vld` toggles every other cycle → exactly 36 `l` pulses and no `l` while `a_vld=0`.
- Output backpressure: `out_rdy` is low for 5 cycles on result 7 → `out_vld` stays high and no `outl`/`cl` occur during the stall. Sixteen results are accepted in total.
- `abort` asserted during the 4th MUL → one cycle of all five clears, then IDLE and `done` stays 0. A subsequent `start` completes a normal job.
- `start` pulsed during LOAD_F → ignored and the job completes unchanged. `rst` during OUT_WAIT → all outputs 0 the same cycle.
- With `CONV_SEQ_PIPE_EN`: default job runs 16×13 compute cycles. `mull`+`addl` are both high on 8 cycles per output.

Source files
------------

// File: rtl/conv_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : conv_seq_ctrl
// Purpose  : Sequencing controller for the single-lane convolution datapath.
//            On start it loads an AS x AS activation tile and an FS x FS
//            filter over valid/ready streams. It then walks every output
//            position running FS*FS multiply-accumulate steps at each, and
//            streams the OS x OS results out. It owns the row/column/shift
//            loop counters mirroring the datapath and drives every datapath
//            clear, load and increment strobe.
// Ports    : clk, rst (async, active-high)
//            start, abort                  - job control
//            a_vld/a_rdy, f_vld/f_rdy      - activation / filter load streams
//            out_vld/out_rdy               - result stream handshake
//            busy, done                    - status (done = 1-cycle pulse)
//            clr rclr cclr sftrclr sftcclr - datapath clears
//            l fl mull addl resultl outl   - datapath loads
//            rl cl sftrl sftcl             - datapath counter increments
//            state[3:0]                    - current state, debug only
// Config   : CONV_SEQ_PIPE_EN - overlaps MUL of element k+1 with ACC of
//            element k (FS*FS+4 cycles per output instead of 2*FS*FS+3).
// Revision : 1.0 - initial release
// ============================================================================
module conv_seq_ctrl #(
    parameter int AS  = 6,
    parameter int FS  = 3,
    parameter int STR = 1,
    parameter int ZP  = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       a_vld,
    input  logic       f_vld,
    output logic       a_rdy,
    output logic       f_rdy,
    output logic       out_vld,
    input  logic       out_rdy,
    output logic       busy,
    output logic       done,
    output logic       clr,
    output logic       rclr,
    output logic       cclr,
    output logic       sftrclr,
    output logic       sftcclr,
    output logic       l,
    output logic       fl,
    output logic       mull,
    output logic       addl,
    output logic       resultl,
    output logic       outl,
    output logic       rl,
    output logic       cl,
    output logic       sftrl,
    output logic       sftcl,
    output logic [3:0] state
);

    localparam int         c_OS     = ((AS + 2 * ZP - FS) / STR) + 1;
    localparam logic [2:0] c_AS_M1  = 3'(AS - 1);
    localparam logic [2:0] c_FS_M1  = 3'(FS - 1);
    localparam logic [2:0] c_FS_M2  = 3'(FS - 2);
    localparam logic [2:0] c_OS_M1  = 3'(c_OS - 1);
    localparam logic [7:0] c_STR    = 8'(STR);
    localparam logic [7:0] c_SEND   = 8'((c_OS - 1) * STR);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_INIT     = 4'd1,
        S_LOAD_A   = 4'd2,
        S_LOAD_F   = 4'd3,
        S_MCLR     = 4'd4,
        S_MUL      = 4'd5,
        S_ACC      = 4'd6,
        S_STORE    = 4'd7,
        S_SHIFT    = 4'd8,
        S_OUT_RD   = 4'd9,
        S_OUT_WAIT = 4'd10,
        S_FIN      = 4'd11
`ifdef CONV_SEQ_PIPE_EN
        ,
        S_MAC      = 4'd12
`endif
    } state_t;

    state_t     r_state, w_next;
    logic [2:0] r_rc, r_cc, w_rc, w_cc;
    logic [7:0] r_sr, r_sc, w_sr, w_sc;
    logic       r_abrt, w_abrt;
    logic [2:0] w_lim;
    logic       w_col_end, w_row_end, w_step;

    // The row/column pair is shared by every phase; only its limit changes.
    always_comb begin
        case (r_state)
            S_LOAD_A:   w_lim = c_AS_M1;
            S_OUT_WAIT: w_lim = c_OS_M1;
            default:    w_lim = c_FS_M1;
        endcase
    end

    assign w_col_end = (r_cc == w_lim);
    assign w_row_end = (r_rc == w_lim);
    assign busy      = (r_state != S_IDLE);
    assign state     = r_state;

    always_comb begin
        w_next  = r_state;
        w_rc    = r_rc;
        w_cc    = r_cc;
        w_sr    = r_sr;
        w_sc    = r_sc;
        w_abrt  = r_abrt;
        w_step  = 1'b0;
        a_rdy   = 1'b0;
        f_rdy   = 1'b0;
        out_vld = 1'b0;
        done    = 1'b0;
        clr     = 1'b0;
        rclr    = 1'b0;
        cclr    = 1'b0;
        sftrclr = 1'b0;
        sftcclr = 1'b0;
        l       = 1'b0;
        fl      = 1'b0;
        mull    = 1'b0;
        addl    = 1'b0;
        resultl = 1'b0;
        outl    = 1'b0;
        rl      = 1'b0;
        cl      = 1'b0;
        sftrl   = 1'b0;
        sftcl   = 1'b0;

        if (abort && (r_state != S_IDLE)) begin
            // Abort wins over any handshake this cycle: nothing is accepted,
            // and the following INIT cycle issues the clears before IDLE.
            w_next = S_INIT;
            w_abrt = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) w_next = S_INIT;
                end
                S_INIT: begin
                    clr     = 1'b1;
                    rclr    = 1'b1;
                    cclr    = 1'b1;
                    sftrclr = 1'b1;
                    sftcclr = 1'b1;
                    w_rc    = '0;
                    w_cc    = '0;
                    w_sr    = '0;
                    w_sc    = '0;
                    w_abrt  = 1'b0;
                    w_next  = r_abrt ? S_IDLE : S_LOAD_A;
                end
                S_LOAD_A: begin
                    a_rdy = 1'b1;
                    if (a_vld) begin
                        l      = 1'b1;
                        w_step = 1'b1;
                        if (w_col_end && w_row_end) w_next = S_LOAD_F;
                    end
                end
                S_LOAD_F: begin
                    f_rdy = 1'b1;
                    if (f_vld) begin
                        fl     = 1'b1;
                        w_step = 1'b1;
                        if (w_col_end && w_row_end) w_next = S_MCLR;
                    end
                end
                S_MCLR: begin
                    clr    = 1'b1;
                    w_next = S_MUL;
                end
                S_MUL: begin
                    mull = 1'b1;
`ifdef CONV_SEQ_PIPE_EN
                    w_next = (FS == 1) ? S_ACC : S_MAC;
`else
                    w_next = S_ACC;
`endif
                end
`ifdef CONV_SEQ_PIPE_EN
                S_MAC: begin
                    // Multiply element k+1 while accumulating element k; the
                    // counter tracks the element being accumulated, so the
                    // hand-off to the draining ACC happens at FS*FS-2.
                    mull   = 1'b1;
                    addl   = 1'b1;
                    w_step = 1'b1;
                    if ((r_rc == c_FS_M1) && (r_cc == c_FS_M2)) w_next = S_ACC;
                end
`endif
                S_ACC: begin
                    addl   = 1'b1;
                    w_step = 1'b1;
                    w_next = (w_col_end && w_row_end) ? S_STORE : S_MUL;
                end
                S_STORE: begin
                    resultl = 1'b1;
                    w_next  = S_SHIFT;
                end
                S_SHIFT: begin
                    w_next = S_MCLR;
                    if (r_sc == c_SEND) begin
                        sftcclr = 1'b1;
                        sftrl   = 1'b1;
                        w_sc    = '0;
                        if (r_sr == c_SEND) begin
                            sftrclr = 1'b1;
                            w_sr    = '0;
                            w_next  = S_OUT_RD;
                        end else begin
                            w_sr = r_sr + c_STR;
                        end
                    end else begin
                        sftcl = 1'b1;
                        w_sc  = r_sc + c_STR;
                    end
                end
                S_OUT_RD: begin
                    outl   = 1'b1;
                    w_next = S_OUT_WAIT;
                end
                S_OUT_WAIT: begin
                    out_vld = 1'b1;
                    if (out_rdy) begin
                        w_step = 1'b1;
                        w_next = (w_col_end && w_row_end) ? S_FIN : S_OUT_RD;
                    end
                end
                S_FIN: begin
                    done   = 1'b1;
                    w_next = S_IDLE;
                end
                default: w_next = S_IDLE;
            endcase

            // Shared row/column step: a column end replaces the column
            // increment with a clear plus row increment; the final row end
            // also clears the row so the pair wraps to (0,0).
            if (w_step) begin
                if (w_col_end) begin
                    cclr = 1'b1;
                    rl   = 1'b1;
                    w_cc = '0;
                    if (w_row_end) begin
                        rclr = 1'b1;
                        w_rc = '0;
                    end else begin
                        w_rc = r_rc + 3'd1;
                    end
                end else begin
                    cl   = 1'b1;
                    w_cc = r_cc + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_rc    <= '0;
            r_cc    <= '0;
            r_sr    <= '0;
            r_sc    <= '0;
            r_abrt  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_rc    <= w_rc;
            r_cc    <= w_cc;
            r_sr    <= w_sr;
            r_sc    <= w_sc;
            r_abrt  <= w_abrt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_seq_ctrl
// Purpose  : Self-checking bench for conv_seq_ctrl (defaults AS=6, FS=3).
//            Table of per-cycle vectors for the start/load/abort path, then
//            full jobs with stall, backpressure, abort and reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_seq_ctrl;

    localparam int E_OS = 4;
`ifdef CONV_SEQ_PIPE_EN
    localparam int E_PER  = 3 * 3 + 4;
    localparam int E_BOTH = 16 * 8;
`else
    localparam int E_PER  = 2 * 3 * 3 + 3;
    localparam int E_BOTH = 0;
`endif
    localparam int E_BUSY = 2 + 36 + 9 + E_OS * E_OS * E_PER + 2 * E_OS * E_OS;

    localparam logic [19:0] M_ARDY = 20'h80000;
    localparam logic [19:0] M_BUSY = 20'h10000;
    localparam logic [19:0] M_CLRS = 20'h07C00;  // clr rclr cclr sftrclr sftcclr
    localparam logic [19:0] M_CCLR = 20'h01000;
    localparam logic [19:0] M_L    = 20'h00200;
    localparam logic [19:0] M_RL   = 20'h00008;
    localparam logic [19:0] M_CL   = 20'h00004;

    logic clk = 1'b0;
    logic rst, start, abort, a_vld, f_vld, out_rdy;
    logic a_rdy, f_rdy, out_vld, busy, done, clr, rclr, cclr, sftrclr, sftcclr;
    logic l, fl, mull, addl, resultl, outl, rl, cl, sftrl, sftcl;
    logic [3:0] state;
    logic [19:0] outs;

    assign outs = {a_rdy, f_rdy, out_vld, busy, done, clr, rclr, cclr, sftrclr, sftcclr,
                   l, fl, mull, addl, resultl, outl, rl, cl, sftrl, sftcl};

    conv_seq_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .a_vld(a_vld), .f_vld(f_vld), .a_rdy(a_rdy), .f_rdy(f_rdy),
        .out_vld(out_vld), .out_rdy(out_rdy), .busy(busy), .done(done),
        .clr(clr), .rclr(rclr), .cclr(cclr), .sftrclr(sftrclr), .sftcclr(sftcclr),
        .l(l), .fl(fl), .mull(mull), .addl(addl), .resultl(resultl), .outl(outl),
        .rl(rl), .cl(cl), .sftrl(sftrl), .sftcl(sftcl), .state(state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic        start;
        logic        abort;
        logic        a_vld;
        logic        f_vld;
        logic        out_rdy;
        logic [3:0]  st;
        logic [19:0] exp;
    } vec_t;

    vec_t tv [16];

    int n_busy, n_done, n_rla, n_rlf, n_l, n_lbad, n_fl, n_acc, n_outl, n_res;
    int n_comp, n_both, n_mull, n_stall, n_stall_err, abort_cyc;
    bit aborted;

    task automatic run_job(input int a_tog, input int stall_res, input int pulse_f,
                           input int abort_mul);
        int cyc = 0;
        int mul_seen = 0;
        bit seen = 0;
        bit pulsed = 0;
        n_busy = 0; n_done = 0; n_rla = 0; n_rlf = 0; n_l = 0; n_lbad = 0; n_fl = 0;
        n_acc = 0; n_outl = 0; n_res = 0; n_comp = 0; n_both = 0; n_mull = 0;
        n_stall = 0; n_stall_err = 0; abort_cyc = -10; aborted = 0;
        while (1) begin
            @(negedge clk);
            start   = (cyc == 0);
            abort   = 1'b0;
            a_vld   = (a_tog != 0) ? ((cyc % 2) == 1) : 1'b1;
            f_vld   = 1'b1;
            out_rdy = 1'b1;
            if ((pulse_f != 0) && (state == 4'd3) && !pulsed) begin
                start  = 1'b1;
                pulsed = 1;
            end
            if ((stall_res >= 0) && (state == 4'd10) && (n_acc == stall_res) && (n_stall < 5)) begin
                out_rdy = 1'b0;
                n_stall++;
            end
            if ((abort_mul > 0) && (state == 4'd5)) begin
                mul_seen++;
                if (mul_seen == abort_mul) begin
                    abort     = 1'b1;
                    abort_cyc = cyc;
                    aborted   = 1;
                end
            end
            #1;
            if (busy) n_busy++;
            if (done) n_done++;
            if (rl && state == 4'd2) n_rla++;
            if (rl && state == 4'd3) n_rlf++;
            if (l) n_l++;
            if (l && !a_vld) n_lbad++;
            if (fl) n_fl++;
            if (out_vld && out_rdy) n_acc++;
            if (outl) n_outl++;
            if (resultl) n_res++;
            if (mull) n_mull++;
            if (mull && addl) n_both++;
            if (state inside {4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd12}) n_comp++;
            if (!out_rdy && state == 4'd10 && (!out_vld || outl || cl)) n_stall_err++;
            if (aborted && cyc == abort_cyc + 1) begin
                chk("abort_clears", 32'(outs), 32'(M_BUSY | M_CLRS));
                chk("abort_init_state", 32'(state), 32'd1);
            end
            if (aborted && cyc == abort_cyc + 2) chk("abort_idle_state", 32'(state), 32'd0);
            if (busy) seen = 1;
            cyc++;
            if (seen && !busy) break;
            if (cyc > 4000) begin
                chk("job_timeout", 32'd0, 32'd1);
                break;
            end
        end
        start = 1'b0; abort = 1'b0; a_vld = 1'b0; f_vld = 1'b0; out_rdy = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; a_vld = 1'b0; f_vld = 1'b0; out_rdy = 1'b0;

        //                start abort a  f  o   state  expected outputs
        tv[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 20'h0};
        tv[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 20'h0};
        tv[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 20'h0};
        tv[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, M_BUSY | M_CLRS};
        tv[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2, M_ARDY | M_BUSY};
        tv[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2, M_ARDY | M_BUSY | M_L | M_CL};
        tv[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd2, M_ARDY | M_BUSY | M_L | M_CL};
        tv[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2, M_ARDY | M_BUSY | M_L | M_CL};
        tv[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2, M_ARDY | M_BUSY | M_L | M_CL};
        tv[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2, M_ARDY | M_BUSY};
        tv[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2, M_ARDY | M_BUSY | M_L | M_CL};
        tv[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2, M_ARDY | M_BUSY | M_L | M_CCLR | M_RL};
        tv[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2, M_ARDY | M_BUSY | M_L | M_CL};
        tv[13] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd2, M_BUSY};
        tv[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, M_BUSY | M_CLRS};
        tv[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 20'h0};

        repeat (2) @(negedge clk);
        #1;
        chk("reset_outs", 32'(outs), 32'd0);
        chk("reset_state", 32'(state), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            {start, abort, a_vld, f_vld, out_rdy} =
                {tv[i].start, tv[i].abort, tv[i].a_vld, tv[i].f_vld, tv[i].out_rdy};
            #1;
            chk($sformatf("vec%0d_state", i), 32'(state), 32'(tv[i].st));
            chk($sformatf("vec%0d_outs", i), 32'(outs), 32'(tv[i].exp));
        end
        start = 1'b0; abort = 1'b0; a_vld = 1'b0; f_vld = 1'b0; out_rdy = 1'b0;

        // Default job, with a stray start pulse during LOAD_F.
        run_job(0, -1, 1, 0);
        chk("job1_busy", n_busy, E_BUSY);
        chk("job1_done", n_done, 1);
        chk("job1_rl_loada", n_rla, 6);
        chk("job1_rl_loadf", n_rlf, 3);
        chk("job1_l", n_l, 36);
        chk("job1_fl", n_fl, 9);
        chk("job1_results", n_acc, 16);
        chk("job1_outl", n_outl, 16);
        chk("job1_resultl", n_res, 16);
        chk("job1_mull", n_mull, 144);
        chk("job1_compute", n_comp, E_OS * E_OS * E_PER);
        chk("job1_mull_addl", n_both, E_BOTH);

        // Activation valid toggling every other cycle.
        run_job(1, -1, 0, 0);
        chk("job2_l", n_l, 36);
        chk("job2_l_no_vld", n_lbad, 0);
        chk("job2_done", n_done, 1);

        // Backpressure on result 7.
        run_job(0, 6, 0, 0);
        chk("job3_results", n_acc, 16);
        chk("job3_stall_cycles", n_stall, 5);
        chk("job3_stall_err", n_stall_err, 0);
        chk("job3_busy", n_busy, E_BUSY + 5);
        chk("job3_done", n_done, 1);

        // Abort during the 4th MUL, then a clean job.
        run_job(0, -1, 0, 4);
        chk("job4_abort_hit", 32'(aborted), 32'd1);
        chk("job4_done", n_done, 0);
        run_job(0, -1, 0, 0);
        chk("job5_busy", n_busy, E_BUSY);
        chk("job5_done", n_done, 1);
        chk("job5_results", n_acc, 16);

        // Reset while waiting on an output.
        @(negedge clk);
        start = 1'b1; a_vld = 1'b1; f_vld = 1'b1; out_rdy = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 2000 && state != 4'd10; c++) @(negedge clk);
        #1;
        chk("pre_rst_state", 32'(state), 32'd10);
        chk("pre_rst_out_vld", 32'(out_vld), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_outs", 32'(outs), 32'd0);
        chk("rst_state", 32'(state), 32'd0);
        @(negedge clk);
        rst = 1'b0; a_vld = 1'b0; f_vld = 1'b0;
        @(negedge clk);
        #1;
        chk("post_rst_state", 32'(state), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
